// File: rtl/spi_egress_pkg.sv
// Shared state encoding and burst-header layout for the SPI egress scheduler.
// The header is {magic, continuation flag, source index}.
package spi_egress_pkg;

  localparam int MAX_SRC = 8;
  localparam int GRANT_W = 3;

  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         HDR_MAGIC_LSB = 4;
  localparam int         HDR_CONT_BIT  = 3;
  localparam int         HDR_GRANT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA
  } egress_state_t;

  function automatic logic [7:0] make_header(input logic cont, input logic [GRANT_W-1:0] grant);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 4]       = HDR_MAGIC;
    hdr[HDR_CONT_BIT]             = cont;
    hdr[HDR_GRANT_LSB +: GRANT_W] = grant;
    return hdr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester at or after last_grant+1,
// wrapping modulo NUM_SRC.
module rr_arbiter
  import spi_egress_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] request,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] grant,
  output logic               grant_valid
);

  logic [MAX_SRC-1:0] req_pad;
  logic [GRANT_W-1:0] idx;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    req_pad     = MAX_SRC'(request);
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = GRANT_W'((int'(last_grant) + i) % NUM_SRC);
      if (req_pad[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_egress_scheduler.sv
// Multiplexes NUM_SRC byte streams into one egress stream as header-prefixed
// bursts of at most MTU_SIZE payload bytes, arbitrated round-robin.
module spi_egress_scheduler
  import spi_egress_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter int         MTU_SIZE  = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic                 clk,
  input  logic                 resn,
  input  logic [NUM_SRC-1:0]   src_enable,
  input  logic [NUM_SRC*8-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [7:0]           m_axis_tuser,
  output logic                 busy,
  output logic [15:0]          burst_count
);

  egress_state_t      state;
  logic [GRANT_W-1:0] grant;
  logic [GRANT_W-1:0] last_grant;
  logic [MAX_SRC-1:0] cont;
  logic [7:0]         byte_cnt;

  logic [GRANT_W-1:0] arb_grant;
  logic               arb_valid;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               mtu_hit;
  logic               data_accept;
  logic               burst_end;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arbiter (
    .request     (s_axis_tvalid & src_enable),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == GRANT_W'(i)) begin
        sel_data  = s_axis_tdata[8*i +: 8];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign mtu_hit     = (byte_cnt == 8'(MTU_SIZE - 1));
  assign data_accept = (state == ST_DATA) && sel_valid && m_axis_tready;
  assign burst_end   = data_accept && (sel_last || mtu_hit);

  // Payload is a zero-latency pass-through of the granted source.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    case (state)
      ST_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = make_header(cont[grant], grant);
      end
      ST_DATA: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tlast  = sel_last | mtu_hit;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant == GRANT_W'(i)) s_axis_tready[i] = m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  assign busy         = (state != ST_IDLE);
  assign m_axis_tuser = IDLE_BYTE;

  // A burst cut by the MTU marks its source so the next header flags continuation.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= GRANT_W'(NUM_SRC - 1);
      cont        <= '0;
      byte_cnt    <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant <= arb_grant;
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (m_axis_tready) begin
            byte_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (burst_end) begin
            state       <= ST_IDLE;
            last_grant  <= grant;
            burst_count <= burst_count + 16'd1;
            cont[grant] <= ~sel_last;
          end else if (data_accept) begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
